serial_digit_adder: RTL and testbench

Parametrised digit-serial adder/subtractor. It adds or subtracts two WIDTH-bit operands DIGIT bits per clock, rippling the carry between cycles through a registered carry flip-flop. It trades latency for area in the datapath and sits behind the ALU operand registers. It supersedes the single-bit combinational adder cells with a start/done handshake, subtract mode, and signed-overflow and carry-out flags.

---
 rtl/alu_pkg.sv | 17 +
 rtl/digit_adder.sv | 35 +++
 rtl/half_adder.sv | 15 +
 rtl/serial_digit_adder.sv | 121 ++++++++++++
 tb/tb_serial_digit_adder.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and sizing helpers for the digit-serial adder
//   sda_state_t  : FSM state encoding (IDLE, RUN, DONE)
//   sda_steps    : number of digit steps N = WIDTH/DIGIT
//   sda_cnt_w    : step counter width, $clog2(N)+1 so N-1 never wraps
package alu_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sda_state_t;

    function automatic int sda_steps(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int sda_cnt_w(input int width, input int digit);
        return $clog2(width / digit) + 1;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple adder built from half-adder cells
//   i_x, i_y    : DIGIT-bit operands
//   i_ci        : carry in
//   o_s         : DIGIT-bit sum
//   o_co        : carry out of the top bit
//   o_c_msb_in  : carry into the top bit (feeds signed-overflow detection)
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_x,
    input  logic [DIGIT-1:0] i_y,
    input  logic             i_ci,
    output logic [DIGIT-1:0] o_s,
    output logic             o_co,
    output logic             o_c_msb_in
);

    logic [DIGIT:0]   w_c;
    logic [DIGIT-1:0] w_p;
    logic [DIGIT-1:0] w_g1;
    logic [DIGIT-1:0] w_g2;

    assign w_c[0] = i_ci;

    // Each full adder is two half adders; the two carries can never both be set.
    for (genvar g = 0; g < DIGIT; g++) begin : g_fa
        half_adder u_ha0 (.i_a(i_x[g]), .i_b(i_y[g]), .o_s(w_p[g]), .o_c(w_g1[g]));
        half_adder u_ha1 (.i_a(w_p[g]), .i_b(w_c[g]), .o_s(o_s[g]), .o_c(w_g2[g]));
        assign w_c[g+1] = w_g1[g] | w_g2[g];
    end

    assign o_co       = w_c[DIGIT];
    assign o_c_msb_in = w_c[DIGIT-1];

endmodule

// File: rtl/half_adder.sv
// half_adder: one-bit half-adder cell
//   i_a, i_b : addend bits
//   o_s      : sum bit
//   o_c      : carry bit
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;

endmodule

// File: rtl/serial_digit_adder.sv
// serial_digit_adder: digit-serial add/subtract, DIGIT bits per cycle with a registered carry
//   clk, rst  : clock, synchronous active-high reset
//   i_start   : request, accepted in IDLE or DONE
//   i_sub     : 1 = a-b, 0 = a+b+cin
//   i_a, i_b  : WIDTH-bit operands
//   i_cin     : carry in (add mode only)
//   o_busy    : high while digits are being processed
//   o_done    : one-cycle result-valid pulse
//   o_sum     : result (partial while busy)
//   o_cout    : carry out of the MSB (1 = no borrow when subtracting)
//   o_ovf     : signed overflow
module serial_digit_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int N  = sda_steps(WIDTH, DIGIT);
    localparam int CW = sda_cnt_w(WIDTH, DIGIT);

    if ((DIGIT < 1) || (DIGIT > WIDTH) || (WIDTH % DIGIT != 0)) begin : g_bad_params
        $fatal(1, "serial_digit_adder: WIDTH must be a positive multiple of DIGIT");
    end

    sda_state_t       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;

    logic [DIGIT-1:0] w_s;
    logic             w_co;
    logic             w_c_msb;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_last;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .i_x        (r_a[DIGIT-1:0]),
        .i_y        (r_b[DIGIT-1:0]),
        .i_ci       (r_carry),
        .o_s        (w_s),
        .o_co       (w_co),
        .o_c_msb_in (w_c_msb)
    );

    // New digits enter at the MSB so after N steps the first digit lands at bit 0.
    if (N == 1) begin : g_sum_one
        assign w_sum_next = w_s;
    end else begin : g_sum_shift
        assign w_sum_next = {w_s, r_sum[WIDTH-1:DIGIT]};
    end

    assign w_last = (r_cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_state <= RUN;
                        r_a     <= i_a;
                        r_b     <= i_sub ? ~i_b : i_b;
                        r_carry <= i_sub | i_cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_sum   <= w_sum_next;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_cout  <= w_co;
                        r_ovf   <= w_c_msb ^ w_co;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy = (r_state == RUN);
    assign o_done = (r_state == DONE);
    assign o_sum  = r_sum;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_digit_adder.sv
// tb_serial_digit_adder: directed checks of the digit-serial adder at 8/4 and 32/1
module tb_serial_digit_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic       s8_start, s8_sub, s8_cin;
    logic [7:0] s8_a, s8_b;
    logic       d8_busy, d8_done, d8_cout, d8_ovf;
    logic [7:0] d8_sum;

    logic        s32_start, s32_sub, s32_cin;
    logic [31:0] s32_a, s32_b;
    logic        d32_busy, d32_done, d32_cout, d32_ovf;
    logic [31:0] d32_sum;

    serial_digit_adder #(.WIDTH(8), .DIGIT(4)) u_dut8 (
        .clk(clk), .rst(rst), .i_start(s8_start), .i_sub(s8_sub), .i_a(s8_a), .i_b(s8_b),
        .i_cin(s8_cin), .o_busy(d8_busy), .o_done(d8_done), .o_sum(d8_sum),
        .o_cout(d8_cout), .o_ovf(d8_ovf)
    );

    serial_digit_adder #(.WIDTH(32), .DIGIT(1)) u_dut32 (
        .clk(clk), .rst(rst), .i_start(s32_start), .i_sub(s32_sub), .i_a(s32_a), .i_b(s32_b),
        .i_cin(s32_cin), .o_busy(d32_busy), .o_done(d32_done), .o_sum(d32_sum),
        .o_cout(d32_cout), .o_ovf(d32_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge; returns 1 ns after the accepting edge.
    task automatic go8(input logic sb, input logic [7:0] a, input logic [7:0] b, input logic ci);
        s8_start = 1'b1; s8_sub = sb; s8_a = a; s8_b = b; s8_cin = ci;
        tick();
        s8_start = 1'b0;
    endtask

    task automatic wait8(output int lat);
        lat = 0;
        while (d8_done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic res8(input string tag, input logic [7:0] sum, input logic co, input logic ov);
        int lat;
        wait8(lat);
        chk({tag, "_lat"}, 64'(lat), 64'd2);
        chk({tag, "_done"}, 64'(d8_done), 64'd1);
        chk({tag, "_sum"}, 64'(d8_sum), 64'(sum));
        chk({tag, "_cout"}, 64'(d8_cout), 64'(co));
        chk({tag, "_ovf"}, 64'(d8_ovf), 64'(ov));
    endtask

    initial begin
        int lat;
        int bcnt;
        int pulses;
        rst = 1'b1;
        s8_start = 0; s8_sub = 0; s8_cin = 0; s8_a = 0; s8_b = 0;
        s32_start = 0; s32_sub = 0; s32_cin = 0; s32_a = 0; s32_b = 0;
        tick();
        tick();
        chk("rst_busy", 64'(d8_busy), 64'd0);
        chk("rst_done", 64'(d8_done), 64'd0);
        chk("rst_sum", 64'(d8_sum), 64'd0);
        chk("rst_cout", 64'(d8_cout), 64'd0);
        chk("rst_ovf", 64'(d8_ovf), 64'd0);
        rst = 1'b0;
        tick();

        go8(1'b0, 8'h3C, 8'h47, 1'b0);
        chk("add1_busy", 64'(d8_busy), 64'd1);
        res8("add1", 8'h83, 1'b0, 1'b1);
        tick();
        chk("add1_done_once", 64'(d8_done), 64'd0);
        chk("add1_sum_held", 64'(d8_sum), 64'h83);

        go8(1'b1, 8'h05, 8'h07, 1'b1);
        res8("sub1", 8'hFE, 1'b0, 1'b0);
        tick();
        go8(1'b1, 8'h80, 8'h01, 1'b0);
        res8("sub2", 8'h7F, 1'b1, 1'b1);
        tick();
        go8(1'b0, 8'hFF, 8'h01, 1'b1);
        res8("addc", 8'h01, 1'b1, 1'b0);
        tick();
        go8(1'b0, 8'h7F, 8'h01, 1'b0);
        res8("addov", 8'h80, 1'b0, 1'b1);
        tick();

        s32_start = 1'b1; s32_sub = 1'b0; s32_a = 32'hFFFF_FFFF; s32_b = 32'h0; s32_cin = 1'b1;
        tick();
        s32_start = 1'b0;
        lat = 0;
        bcnt = 0;
        while (d32_done !== 1'b1 && lat < 100) begin
            if (d32_busy === 1'b1) bcnt++;
            tick();
            lat++;
        end
        chk("w32_lat", 64'(lat), 64'd32);
        chk("w32_busy_cycles", 64'(bcnt), 64'd32);
        chk("w32_sum", 64'(d32_sum), 64'h0);
        chk("w32_cout", 64'(d32_cout), 64'd1);
        chk("w32_ovf", 64'(d32_ovf), 64'd0);
        chk("w32_busy_done", 64'(d32_busy), 64'd0);
        tick();

        go8(1'b0, 8'h12, 8'h34, 1'b0);
        s8_start = 1'b1; s8_a = 8'hFF; s8_b = 8'hFF; s8_cin = 1'b1;
        tick();
        chk("ign_done_c1", 64'(d8_done), 64'd0);
        tick();
        s8_start = 1'b0;
        chk("ign_done", 64'(d8_done), 64'd1);
        chk("ign_sum", 64'(d8_sum), 64'h46);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (d8_done === 1'b1) pulses++;
        end
        chk("ign_extra_done", 64'(pulses), 64'd0);
        chk("ign_idle_busy", 64'(d8_busy), 64'd0);

        s8_start = 1'b1; s8_sub = 1'b0; s8_a = 8'h10; s8_b = 8'h20; s8_cin = 1'b0;
        tick();
        tick();
        tick();
        chk("b2b_done1", 64'(d8_done), 64'd1);
        chk("b2b_sum1", 64'(d8_sum), 64'h30);
        s8_sub = 1'b1; s8_a = 8'h50; s8_b = 8'h10;
        tick();
        s8_start = 1'b0;
        chk("b2b_busy", 64'(d8_busy), 64'd1);
        chk("b2b_nodone", 64'(d8_done), 64'd0);
        tick();
        tick();
        chk("b2b_done2", 64'(d8_done), 64'd1);
        chk("b2b_sum2", 64'(d8_sum), 64'h40);
        chk("b2b_cout2", 64'(d8_cout), 64'd1);
        chk("b2b_ovf2", 64'(d8_ovf), 64'd0);
        tick();

        go8(1'b0, 8'h3C, 8'h47, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(d8_busy), 64'd0);
        chk("abort_done", 64'(d8_done), 64'd0);
        chk("abort_sum", 64'(d8_sum), 64'd0);
        chk("abort_cout", 64'(d8_cout), 64'd0);
        chk("abort_ovf", 64'(d8_ovf), 64'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (d8_done === 1'b1) pulses++;
        end
        chk("abort_no_done", 64'(pulses), 64'd0);
        go8(1'b1, 8'h05, 8'h07, 1'b0);
        res8("after_abort", 8'hFE, 1'b0, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
